id_ex_reg: RTL and testbench
============================

Name: id_ex_reg

Overview:
Decode-to-execute pipeline register of the pipelined RV32 core. Captures the decode-stage control bundle (RegWrite, ResultSrc, MemWrite, Jump, Branch, ALUControl, ALUSrc) and the decode datapath fields. Presents them to the execute stage one cycle later. Supports the hazard unit's flush (bubble insertion) and stall (hold) requests, and carries a valid bit so that downstream logic can tell bubbles from real instructions.

Parameters:
XLEN, 32, datapath width of register operands, PC and immediate.
REG_ADDR_W, 5, width of register-file address fields.

Ports:
clk  input  1  core clock; all state updates on rising edge.
reset_n  input  1  asynchronous, active-low reset.
StallE  input  1  hold current E-stage contents.
FlushE  input  1  replace the next E-stage contents with a bubble.
ValidD  input  1  decode slot holds a real instruction.
RegWriteD  input  1  decode control.
ResultSrcD  input  2  decode control.
MemWriteD  input  1  decode control.
JumpD  input  1  decode control.
BranchD  input  1  decode control.
ALUControlD  input  3  decode control.
ALUSrcD  input  1  decode control.
RD1D  input  XLEN  register file read data 1.
RD2D  input  XLEN  register file read data 2.
PCD  input  XLEN  instruction PC.
PCPlus4D  input  XLEN  PC+4.
ImmExtD  input  XLEN  extended immediate.
Rs1D  input  REG_ADDR_W  source register 1.
Rs2D  input  REG_ADDR_W  source register 2.
RdD  input  REG_ADDR_W  destination register.
ValidE, RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE, ALUSrcE, RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE  output  (same widths as D counterparts)  registered E-stage copies.
BubbleCountE  output  32  count of flush-inserted bubbles (see Optional Feature).

Behaviour:
- Reset: reset_n=0 asynchronously forces every E output and BubbleCountE to 0. Release is synchronous to the next rising edge, with no extra latency.
- Latency: exactly 1 cycle from D inputs to E outputs when there is no stall and no flush.
- Per rising edge, priority is FlushE > StallE > load:
  - FlushE=1: every E output becomes 0, including ValidE, all control and all data fields. A bubble is therefore a full NOP: no register write, no memory write, no branch or jump. This applies regardless of StallE.
  - StallE=1, FlushE=0: all E outputs hold their value.
  - Otherwise: every E output is loaded from its D counterpart, and ValidE is loaded from ValidD.
- ValidD=0 with no flush: the controls are still loaded verbatim. ValidE=0 is the only bubble indication in this case; control fields are not masked.
- Flush and stall asserted together: the flush wins and a bubble is inserted. The stall is not remembered in the next cycle.
- Reset asserted mid-stall or mid-flush: reset dominates immediately; the E outputs go to 0 without waiting for a clock edge.
- The block contains no combinational path from D inputs to E outputs; every output is a flop.

Optional Feature:
Macro ID_EX_BUBBLE_CNT_EN.
- Defined: BubbleCountE increments by 1 on each rising edge where FlushE=1, including when StallE=1. It saturates at 0xFFFFFFFF and does not wrap. It is cleared only by reset.
- Undefined: BubbleCountE is tied to constant 0 and the counter logic is absent. The port remains present in both builds.

Test Plan:
- Reset: drive reset_n=0 mid-cycle with RegWriteD=1 and RD1D=0xDEADBEEF loaded. All E outputs read 0 before the next edge. With the feature enabled, BubbleCountE=0.
- Pass-through: load RegWriteD=1, ResultSrcD=2'b01, ALUControlD=3'b010, RD1D=0x00000010, RdD=5 and ValidD=1 with no stall or flush. One edge later the E outputs equal these values and ValidE=1.
- Stall: after a load, set StallE=1 for 3 cycles while the D inputs change to RdD=7 and RD2D=0x55. The E outputs keep their prior values (RdE=5) until StallE drops. One edge later RdE=7.
- Flush: set MemWriteD=1, BranchD=1, JumpD=1 and FlushE=1. After the edge, every E output is 0, including ValidE. The next unflushed edge loads normally.
- Flush with stall: set FlushE=1 and StallE=1 together, with E currently holding RdE=5. After the edge RdE=0 and ValidE=0. With the feature enabled, BubbleCountE increments by 1.
- Saturation (ID_EX_BUBBLE_CNT_EN): force the counter to 0xFFFFFFFE and apply 3 flush cycles. BubbleCountE reads 0xFFFFFFFF and stays there. With the macro undefined, the same stimulus gives BubbleCountE=0.

Source files
------------

// File: rtl/id_ex_reg.sv
// id_ex_reg: decode-to-execute pipeline register of the pipelined RV32 core.
// Captures the decode control bundle and datapath fields and presents them to
// the execute stage one cycle later. Flush inserts a full NOP bubble and takes
// priority over stall. ValidE tells real instructions apart from bubbles.
// Optional build macro ID_EX_BUBBLE_CNT_EN adds a saturating counter of
// flush-inserted bubbles on BubbleCountE. Without it the port is tied to 0.
module id_ex_reg #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  StallE,
  input  logic                  FlushE,
  input  logic                  ValidD,
  input  logic                  RegWriteD,
  input  logic [1:0]            ResultSrcD,
  input  logic                  MemWriteD,
  input  logic                  JumpD,
  input  logic                  BranchD,
  input  logic [2:0]            ALUControlD,
  input  logic                  ALUSrcD,
  input  logic [XLEN-1:0]       RD1D,
  input  logic [XLEN-1:0]       RD2D,
  input  logic [XLEN-1:0]       PCD,
  input  logic [XLEN-1:0]       PCPlus4D,
  input  logic [XLEN-1:0]       ImmExtD,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] RdD,
  output logic                  ValidE,
  output logic                  RegWriteE,
  output logic [1:0]            ResultSrcE,
  output logic                  MemWriteE,
  output logic                  JumpE,
  output logic                  BranchE,
  output logic [2:0]            ALUControlE,
  output logic                  ALUSrcE,
  output logic [XLEN-1:0]       RD1E,
  output logic [XLEN-1:0]       RD2E,
  output logic [XLEN-1:0]       PCE,
  output logic [XLEN-1:0]       PCPlus4E,
  output logic [XLEN-1:0]       ImmExtE,
  output logic [REG_ADDR_W-1:0] Rs1E,
  output logic [REG_ADDR_W-1:0] Rs2E,
  output logic [REG_ADDR_W-1:0] RdE,
  output logic [31:0]           BubbleCountE
);

  logic                  r_valid_p1;
  logic                  r_reg_write_p1;
  logic [1:0]            r_result_src_p1;
  logic                  r_mem_write_p1;
  logic                  r_jump_p1;
  logic                  r_branch_p1;
  logic [2:0]            r_alu_control_p1;
  logic                  r_alu_src_p1;
  logic [XLEN-1:0]       r_rd1_p1;
  logic [XLEN-1:0]       r_rd2_p1;
  logic [XLEN-1:0]       r_pc_p1;
  logic [XLEN-1:0]       r_pc_plus4_p1;
  logic [XLEN-1:0]       r_imm_ext_p1;
  logic [REG_ADDR_W-1:0] r_rs1_p1;
  logic [REG_ADDR_W-1:0] r_rs2_p1;
  logic [REG_ADDR_W-1:0] r_rd_p1;

  // D -> E stage boundary: flush zeroes everything, stall holds, else load
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n || FlushE) begin
      r_valid_p1       <= 1'b0;
      r_reg_write_p1   <= 1'b0;
      r_result_src_p1  <= '0;
      r_mem_write_p1   <= 1'b0;
      r_jump_p1        <= 1'b0;
      r_branch_p1      <= 1'b0;
      r_alu_control_p1 <= '0;
      r_alu_src_p1     <= 1'b0;
      r_rd1_p1         <= '0;
      r_rd2_p1         <= '0;
      r_pc_p1          <= '0;
      r_pc_plus4_p1    <= '0;
      r_imm_ext_p1     <= '0;
      r_rs1_p1         <= '0;
      r_rs2_p1         <= '0;
      r_rd_p1          <= '0;
    end else if (!StallE) begin
      r_valid_p1       <= ValidD;
      r_reg_write_p1   <= RegWriteD;
      r_result_src_p1  <= ResultSrcD;
      r_mem_write_p1   <= MemWriteD;
      r_jump_p1        <= JumpD;
      r_branch_p1      <= BranchD;
      r_alu_control_p1 <= ALUControlD;
      r_alu_src_p1     <= ALUSrcD;
      r_rd1_p1         <= RD1D;
      r_rd2_p1         <= RD2D;
      r_pc_p1          <= PCD;
      r_pc_plus4_p1    <= PCPlus4D;
      r_imm_ext_p1     <= ImmExtD;
      r_rs1_p1         <= Rs1D;
      r_rs2_p1         <= Rs2D;
      r_rd_p1          <= RdD;
    end
  end

  assign ValidE      = r_valid_p1;
  assign RegWriteE   = r_reg_write_p1;
  assign ResultSrcE  = r_result_src_p1;
  assign MemWriteE   = r_mem_write_p1;
  assign JumpE       = r_jump_p1;
  assign BranchE     = r_branch_p1;
  assign ALUControlE = r_alu_control_p1;
  assign ALUSrcE     = r_alu_src_p1;
  assign RD1E        = r_rd1_p1;
  assign RD2E        = r_rd2_p1;
  assign PCE         = r_pc_p1;
  assign PCPlus4E    = r_pc_plus4_p1;
  assign ImmExtE     = r_imm_ext_p1;
  assign Rs1E        = r_rs1_p1;
  assign Rs2E        = r_rs2_p1;
  assign RdE         = r_rd_p1;

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [31:0] r_bubble_cnt;

  // Bubble counter: one per flushed edge (stall irrelevant), sticks at all-ones
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bubble_cnt <= '0;
    end else if (FlushE && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
      r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign BubbleCountE = r_bubble_cnt;
`else
  assign BubbleCountE = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// tb_id_ex_reg: randomized and directed self-checking bench for id_ex_reg.
// The reference model treats the E stage as one instruction bundle that is
// replaced by D, replaced by a NOP, or kept, according to the flush/stall rules.
module tb_id_ex_reg;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic [1:0]  result_src;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic [2:0]  alu_control;
    logic        alu_src;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } bundle_t;

  logic    clk;
  logic    reset_n;
  logic    StallE;
  logic    FlushE;
  bundle_t d;

  logic        ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE, BubbleCountE;
  logic [4:0]  Rs1E, Rs2E, RdE;
  bundle_t     obs;

  assign obs = {ValidE, RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE,
                ALUControlE, ALUSrcE, RD1E, RD2E, PCE, PCPlus4E, ImmExtE,
                Rs1E, Rs2E, RdE};

  // reference model state
  bundle_t         exp_e;
  longint unsigned exp_cnt;

  int checks = 0;
  int fails  = 0;

  id_ex_reg #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .StallE(StallE), .FlushE(FlushE),
    .ValidD(d.valid), .RegWriteD(d.reg_write), .ResultSrcD(d.result_src),
    .MemWriteD(d.mem_write), .JumpD(d.jump), .BranchD(d.branch),
    .ALUControlD(d.alu_control), .ALUSrcD(d.alu_src),
    .RD1D(d.rd1), .RD2D(d.rd2), .PCD(d.pc), .PCPlus4D(d.pc_plus4),
    .ImmExtD(d.imm), .Rs1D(d.rs1), .Rs2D(d.rs2), .RdD(d.rd),
    .ValidE(ValidE), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
    .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
    .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
    .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .ImmExtE(ImmExtE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .BubbleCountE(BubbleCountE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_count();
`ifdef ID_EX_BUBBLE_CNT_EN
    return exp_cnt[31:0];
`else
    return 32'd0;
`endif
  endfunction

  function automatic bundle_t rand_bundle();
    bundle_t b;
    b.valid       = 1'($urandom);
    b.reg_write   = 1'($urandom);
    b.result_src  = 2'($urandom);
    b.mem_write   = 1'($urandom);
    b.jump        = 1'($urandom);
    b.branch      = 1'($urandom);
    b.alu_control = 3'($urandom);
    b.alu_src     = 1'($urandom);
    b.rd1         = $urandom;
    b.rd2         = $urandom;
    b.pc          = $urandom;
    b.pc_plus4    = $urandom;
    b.imm         = $urandom;
    b.rs1         = 5'($urandom);
    b.rs2         = 5'($urandom);
    b.rd          = 5'($urandom);
    return b;
  endfunction

  // one clock with the given hazard controls; model advances with the edge
  task automatic cycle(input logic stall, input logic flush);
    bundle_t nxt;
    StallE = stall;
    FlushE = flush;
    if (flush) nxt = '0;
    else if (stall) nxt = exp_e;
    else nxt = d;
    @(posedge clk);
    exp_e = nxt;
    if (flush && exp_cnt < 64'hFFFF_FFFF) exp_cnt = exp_cnt + 1;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; StallE = 1'b0; FlushE = 1'b0; d = '0;
    exp_e = '0; exp_cnt = 0;
    #12;
    checks++;
    if (obs !== '0) begin
      $display("FAIL reset_initial: got %h required 0", obs); fails++;
    end
    checks++;
    if (BubbleCountE !== 32'd0) begin
      $display("FAIL reset_count: got %h required 0", BubbleCountE); fails++;
    end
    reset_n = 1'b1;
    d.reg_write = 1'b1; d.rd1 = 32'hDEADBEEF; d.valid = 1'b1;
    cycle(1'b0, 1'b0);
    checks++;
    if (RD1E !== 32'hDEADBEEF || RegWriteE !== 1'b1) begin
      $display("FAIL reset_preload: got rd1=%h rw=%b required deadbeef/1", RD1E, RegWriteE); fails++;
    end
    // async assertion mid-cycle, checked before the next edge
    #2 reset_n = 1'b0;
    exp_e = '0; exp_cnt = 0;
    #1;
    checks++;
    if (obs !== '0) begin
      $display("FAIL reset_async: got %h required 0", obs); fails++;
    end
    checks++;
    if (BubbleCountE !== 32'd0) begin
      $display("FAIL reset_async_count: got %h required 0", BubbleCountE); fails++;
    end
    #1 reset_n = 1'b1;
  endtask

  task automatic test_pass_through();
    d = '0;
    d.valid = 1'b1; d.reg_write = 1'b1; d.result_src = 2'b01;
    d.alu_control = 3'b010; d.rd1 = 32'h0000_0010; d.rd = 5'd5;
    cycle(1'b0, 1'b0);
    checks++;
    if (obs !== exp_e) begin
      $display("FAIL pass_through: got %h required %h", obs, exp_e); fails++;
    end
    checks++;
    if (ValidE !== 1'b1 || RdE !== 5'd5 || ResultSrcE !== 2'b01 ||
        ALUControlE !== 3'b010 || RD1E !== 32'h10) begin
      $display("FAIL pass_fields: got v=%b rd=%0d rs=%b alu=%b rd1=%h required 1/5/01/010/10",
               ValidE, RdE, ResultSrcE, ALUControlE, RD1E); fails++;
    end
    // invalid slot: controls loaded verbatim, only ValidE drops
    d.valid = 1'b0; d.mem_write = 1'b1;
    cycle(1'b0, 1'b0);
    checks++;
    if (ValidE !== 1'b0 || MemWriteE !== 1'b1 || RegWriteE !== 1'b1) begin
      $display("FAIL invalid_unmasked: got v=%b mw=%b rw=%b required 0/1/1",
               ValidE, MemWriteE, RegWriteE); fails++;
    end
  endtask

  task automatic test_stall();
    d = '0; d.valid = 1'b1; d.reg_write = 1'b1; d.rd = 5'd5; d.rd2 = 32'h11;
    cycle(1'b0, 1'b0);
    d.rd = 5'd7; d.rd2 = 32'h55;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0);
      checks++;
      if (RdE !== 5'd5 || RD2E !== 32'h11 || obs !== exp_e) begin
        $display("FAIL stall_hold%0d: got rd=%0d rd2=%h required 5/11", i, RdE, RD2E); fails++;
      end
    end
    cycle(1'b0, 1'b0);
    checks++;
    if (RdE !== 5'd7 || RD2E !== 32'h55 || obs !== exp_e) begin
      $display("FAIL stall_release: got rd=%0d rd2=%h required 7/55", RdE, RD2E); fails++;
    end
  endtask

  task automatic test_flush();
    logic [31:0] cnt_before;
    cnt_before = BubbleCountE;
    d = rand_bundle(); d.mem_write = 1'b1; d.branch = 1'b1; d.jump = 1'b1; d.valid = 1'b1;
    cycle(1'b0, 1'b1);
    checks++;
    if (obs !== '0) begin
      $display("FAIL flush_bubble: got %h required 0", obs); fails++;
    end
    checks++;
    if (BubbleCountE !== exp_count()) begin
      $display("FAIL flush_count: got %h required %h (was %h)", BubbleCountE, exp_count(), cnt_before); fails++;
    end
    cycle(1'b0, 1'b0);
    checks++;
    if (obs !== exp_e || ValidE !== 1'b1) begin
      $display("FAIL flush_reload: got %h required %h", obs, exp_e); fails++;
    end
  endtask

  task automatic test_flush_with_stall();
    d = '0; d.valid = 1'b1; d.rd = 5'd5; d.reg_write = 1'b1;
    cycle(1'b0, 1'b0);
    d.rd = 5'd9;
    cycle(1'b1, 1'b1);
    checks++;
    if (RdE !== 5'd0 || ValidE !== 1'b0 || obs !== '0) begin
      $display("FAIL flush_stall: got rd=%0d v=%b required 0/0", RdE, ValidE); fails++;
    end
    checks++;
    if (BubbleCountE !== exp_count()) begin
      $display("FAIL flush_stall_count: got %h required %h", BubbleCountE, exp_count()); fails++;
    end
    // stall is not remembered
    cycle(1'b0, 1'b0);
    checks++;
    if (RdE !== 5'd9 || obs !== exp_e) begin
      $display("FAIL flush_stall_after: got rd=%0d required 9", RdE); fails++;
    end
  endtask

  task automatic test_reset_mid_stall();
    d = rand_bundle(); d.valid = 1'b1;
    cycle(1'b0, 1'b0);
    StallE = 1'b1; FlushE = 1'b1;
    #2 reset_n = 1'b0;
    exp_e = '0; exp_cnt = 0;
    #1;
    checks++;
    if (obs !== '0 || BubbleCountE !== 32'd0) begin
      $display("FAIL reset_mid_stall: got %h cnt=%h required 0", obs, BubbleCountE); fails++;
    end
    StallE = 1'b0; FlushE = 1'b0;
    #1 reset_n = 1'b1;
  endtask

  task automatic test_saturation();
`ifdef ID_EX_BUBBLE_CNT_EN
    @(negedge clk);
    force dut.r_bubble_cnt = 32'hFFFF_FFFE;
    #1 release dut.r_bubble_cnt;
    exp_cnt = 64'hFFFF_FFFE;
`endif
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1);
      checks++;
`ifdef ID_EX_BUBBLE_CNT_EN
      if (BubbleCountE !== 32'hFFFF_FFFF) begin
        $display("FAIL saturation%0d: got %h required ffffffff", i, BubbleCountE); fails++;
      end
`else
      if (BubbleCountE !== 32'd0) begin
        $display("FAIL saturation%0d: got %h required 0", i, BubbleCountE); fails++;
      end
`endif
    end
  endtask

  task automatic test_random();
    logic s, f;
    for (int i = 0; i < 300; i++) begin
      d = rand_bundle();
      s = ($urandom_range(0, 3) == 0);
      f = ($urandom_range(0, 7) == 0);
      cycle(s, f);
      checks++;
      if (obs !== exp_e) begin
        $display("FAIL random%0d (s=%b f=%b): got %h required %h", i, s, f, obs, exp_e); fails++;
      end
      checks++;
      if (BubbleCountE !== exp_count()) begin
        $display("FAIL random_count%0d: got %h required %h", i, BubbleCountE, exp_count()); fails++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_stall();
    test_flush();
    test_flush_with_stall();
    test_random();
    test_reset_mid_stall();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
